// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the single-cycle MIPS core and its program loader.
// Contents:
//   ldr_state_e     - state encoding of the instruction-memory loader FSM
//   LDR_HDR_BYTES   - number of length bytes that precede a loader image
//   BYTES_PER_WORD  - bytes per instruction word (big-endian in the stream)
package mips_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN_HI,
        LDR_LEN_LO,
        LDR_DATA,
        LDR_WRITE,
        LDR_CSUM,
        LDR_DONE,
        LDR_ERR
    } ldr_state_e;

    localparam int LDR_HDR_BYTES  = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Writer side of the instruction memory. Receives a length-prefixed,
// XOR-checksummed byte stream, assembles big-endian 32-bit words and writes
// them to consecutive word-aligned byte addresses starting at 0. The core is
// held in reset until a complete, checksum-clean image has been written.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   start              - one-cycle pulse that opens a load session
//   rx_valid/rx_data   - incoming stream byte
//   rx_ready           - loader can take a byte this cycle
//   im_we/im_addr/im_wdata - instruction-memory write port (byte address)
//   cpu_hold           - drives the core's reset, 1 = core held
//   done / err         - session result levels
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // One extra bit so that a full 2**ADDR_W image can be represented.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    ldr_state_e  state_q;
    logic [15:0] len_q;
    logic [15:0] len_d;
    logic [15:0] word_idx_q;
    logic [15:0] word_idx_d;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;
    logic [31:0] asm_d;
    logic [7:0]  csum_q;
    logic [7:0]  csum_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;

    // Ready depends only on state so there is no path from rx_valid to
    // rx_ready. The assembly register only keeps the first three bytes of a
    // word; the fourth byte goes straight into the write-data register.
    always_comb begin
        rx_ready   = (state_q == LDR_LEN_HI) || (state_q == LDR_LEN_LO) ||
                     (state_q == LDR_DATA)   || (state_q == LDR_CSUM);
        accept     = rx_valid && rx_ready;
        asm_d      = {asm_q, rx_data};
        csum_d     = csum_q ^ rx_data;
        len_d      = {len_q[7:0], rx_data};
        word_idx_d = word_idx_q + 16'd1;
    end

    // Loader FSM. The word index is 16 bits wide so that it reaches N without
    // wrapping even when N equals the full memory capacity; only its low
    // ADDR_W bits ever appear on the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LDR_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                LDR_IDLE: begin
                    if (start) begin
                        csum_q  <= '0;
                        state_q <= LDR_LEN_HI;
                    end
                end
                LDR_LEN_HI: begin
                    if (accept) begin
                        len_q   <= {8'h00, rx_data};
                        state_q <= LDR_LEN_LO;
                    end
                end
                LDR_LEN_LO: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (len_d == 16'd0) begin
                            state_q <= LDR_CSUM;
                        end else if ({1'b0, len_d} > MAX_WORDS) begin
                            state_q <= LDR_ERR;
                        end else begin
                            byte_cnt_q <= '0;
                            word_idx_q <= '0;
                            state_q    <= LDR_DATA;
                        end
                    end
                end
                LDR_DATA: begin
                    if (accept) begin
                        asm_q      <= asm_d[23:0];
                        csum_q     <= csum_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            addr_q  <= 32'({word_idx_q[ADDR_W-1:0], 2'b00});
                            wdata_q <= asm_d;
                            state_q <= LDR_WRITE;
                        end
                    end
                end
                LDR_WRITE: begin
                    word_idx_q <= word_idx_d;
                    state_q    <= (word_idx_d == len_q) ? LDR_CSUM : LDR_DATA;
                end
                LDR_CSUM: begin
                    if (accept) begin
                        state_q <= (rx_data == csum_q) ? LDR_DONE : LDR_ERR;
                    end
                end
                LDR_DONE, LDR_ERR: begin
                    if (start) begin
                        csum_q  <= '0;
                        state_q <= LDR_LEN_HI;
                    end
                end
                default: state_q <= LDR_IDLE;
            endcase
        end
    end

    // Status outputs are pure state decodes; the core stays held everywhere
    // except in DONE.
    assign im_we    = (state_q == LDR_WRITE);
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign done     = (state_q == LDR_DONE);
    assign err      = (state_q == LDR_ERR);
    assign cpu_hold = (state_q != LDR_DONE);

endmodule
